// File: rtl/alu_vector_seq_if.sv
// Request/response bundle for the sequential SIMD ALU.
// The master drives operands and out_ready. The slave returns results and per-lane {N,Z,C,V} flags.
interface alu_vector_seq_if #(
  parameter int N     = 32,
  parameter int LANES = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*N-1:0]   A;
  logic [LANES*N-1:0]   B;
  logic [2:0]           ALUControl;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*N-1:0]   result;
  logic [LANES*4-1:0]   flags;

  modport master (
    output in_valid, A, B, ALUControl, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, A, B, ALUControl, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_vector_seq.sv
// Sequential SIMD ALU: single-cycle lane ops, N-cycle shift-add multiply, result held until consumed.
// Each lane computes independently and returns its own {N,Z,C,V} flags.
module alu_vector_seq #(
  parameter int N     = 32,
  parameter int LANES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_vector_seq_if.slave   bus
);

  localparam int SW = $clog2(N);
  localparam int CW = $clog2(N) + 1;
  localparam logic [N-1:0] NVAL = N'(N);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Single-cycle lane op; returns {N,Z,C,V, result}. Mul is produced by the iterative path instead.
  function automatic logic [N+3:0] alu_lane(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [2:0] op);
    logic [N:0]   wide;
    logic [N-1:0] r;
    logic         c;
    logic         v;
    wide = '0;
    r    = '0;
    c    = 1'b0;
    v    = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[N-1:0];
        c    = wide[N];
        v    = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      OP_SUB: begin
        wide = {1'b0, a} - {1'b0, b};
        r    = wide[N-1:0];
        c    = wide[N];
        v    = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      OP_SLL: begin
        if (b >= NVAL) r = '0;
        else           r = a << b[SW-1:0];
      end
      OP_SRL: begin
        if (b >= NVAL) r = '0;
        else           r = a >> b[SW-1:0];
      end
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_OR:   r = a | b;
      default: r = '0;
    endcase
    return {r[N-1], (r == '0), c, v, r};
  endfunction

  function automatic logic [N+3:0] mul_pack(input logic [2*N-1:0] p);
    return {p[N-1], (p[N-1:0] == '0), 1'b0, (p[2*N-1:N] != '0), p[N-1:0]};
  endfunction

  state_t              state_r;
  state_t              state_nx_s;
  logic [CW-1:0]       cnt_r;
  logic [2*N-1:0]      acc_r    [LANES];
  logic [2*N-1:0]      mcand_r  [LANES];
  logic [N-1:0]        mplier_r [LANES];
  logic [2*N-1:0]      acc_nx_s [LANES];
  logic [LANES*N-1:0]  result_r;
  logic [LANES*4-1:0]  flags_r;
  logic                out_valid_r;
  logic                in_ready_r;
  logic [LANES*N-1:0]  alu_res_s;
  logic [LANES*4-1:0]  alu_flg_s;
  logic [LANES*N-1:0]  mul_res_s;
  logic [LANES*4-1:0]  mul_flg_s;
  logic                accept_s;
  logic                last_s;

  assign accept_s      = bus.in_valid && (state_r == IDLE);
  assign last_s        = (cnt_r == CW'(N - 1));
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.flags     = flags_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nx_s;
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (bus.ALUControl == OP_MUL) state_nx_s = MUL;
          else                          state_nx_s = DONE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      MUL: begin
        if (last_s) state_nx_s = DONE;
        else        state_nx_s = MUL;
      end
      DONE: begin
        if (bus.out_ready) state_nx_s = IDLE;
        else               state_nx_s = DONE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Per-lane combinational results and one shift-add multiplier step.
  always_comb begin
    alu_res_s = '0;
    alu_flg_s = '0;
    mul_res_s = '0;
    mul_flg_s = '0;
    acc_nx_s  = '{default: '0};
    for (int i = 0; i < LANES; i++) begin
      {alu_flg_s[i*4 +: 4], alu_res_s[i*N +: N]} =
        alu_lane(bus.A[i*N +: N], bus.B[i*N +: N], bus.ALUControl);
      acc_nx_s[i] = mplier_r[i][0] ? (acc_r[i] + mcand_r[i]) : acc_r[i];
      {mul_flg_s[i*4 +: 4], mul_res_s[i*N +: N]} = mul_pack(acc_nx_s[i]);
    end
  end

  // Datapath: operand capture, multiplier iterations and the held output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      result_r    <= '0;
      flags_r     <= '0;
      cnt_r       <= '0;
      for (int i = 0; i < LANES; i++) begin
        acc_r[i]    <= '0;
        mcand_r[i]  <= '0;
        mplier_r[i] <= '0;
      end
    end else begin
      in_ready_r <= (state_nx_s == IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cnt_r <= '0;
            for (int i = 0; i < LANES; i++) begin
              acc_r[i]    <= '0;
              mcand_r[i]  <= {{N{1'b0}}, bus.A[i*N +: N]};
              mplier_r[i] <= bus.B[i*N +: N];
            end
            if (bus.ALUControl != OP_MUL) begin
              result_r    <= alu_res_s;
              flags_r     <= alu_flg_s;
              out_valid_r <= 1'b1;
            end
          end
        end
        MUL: begin
          cnt_r <= cnt_r + CW'(1);
          for (int i = 0; i < LANES; i++) begin
            acc_r[i]    <= acc_nx_s[i];
            mcand_r[i]  <= mcand_r[i] << 1;
            mplier_r[i] <= mplier_r[i] >> 1;
          end
          if (last_s) begin
            result_r    <= mul_res_s;
            flags_r     <= mul_flg_s;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) out_valid_r <= 1'b0;
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_vector_seq.sv
// Scoreboard bench for alu_vector_seq (N=32, LANES=4): a lane model predicts results, flags and latency.
module tb_alu_vector_seq;
  localparam int N     = 32;
  localparam int LANES = 4;
  localparam int W     = N * LANES;

  typedef struct {
    logic [W-1:0] res;
    logic [15:0]  flg;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [W-1:0] last_res;
  logic [15:0]  last_flg;

  always #5 clk = ~clk;

  alu_vector_seq_if #(.N(N), .LANES(LANES)) bus ();
  alu_vector_seq #(.N(N), .LANES(LANES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [35:0] model_lane(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op);
    longint unsigned ua, ub, s;
    longint sa;
    logic [31:0] r;
    logic c, v;
    ua = {32'd0, a};
    ub = {32'd0, b};
    r = 32'd0; c = 1'b0; v = 1'b0; s = 64'd0; sa = 64'sd0;
    case (op)
      3'd0: begin
        s = ua + ub; r = s[31:0]; c = s[32];
        sa = longint'($signed(a)) + longint'($signed(b));
        v = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
      end
      3'd1: begin
        r = a - b; c = (a < b);
        sa = longint'($signed(a)) - longint'($signed(b));
        v = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
      end
      3'd2: begin
        s = ua * ub; r = s[31:0]; v = (s[63:32] != 32'd0);
      end
      3'd3: r = (ub >= 64'd32) ? 32'd0 : (a << b[4:0]);
      3'd4: r = a & b;
      3'd5: r = a ^ b;
      3'd6: r = a | b;
      default: r = (ub >= 64'd32) ? 32'd0 : (a >> b[4:0]);
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    exp_t e;
    logic [35:0] l;
    e.res = '0;
    e.flg = '0;
    for (int i = 0; i < LANES; i++) begin
      l = model_lane(a[i*N +: N], b[i*N +: N], op);
      e.res[i*N +: N] = l[31:0];
      e.flg[i*4 +: 4] = l[35:32];
    end
    e.lat = (op == 3'b010) ? (N + 1) : 1;
    return e;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.ALUControl = op; bus.in_valid = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk);
    sb.push_back(model(a, b, op));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A = {$urandom, $urandom, $urandom, $urandom};
    bus.B = {$urandom, $urandom, $urandom, $urandom};
    bus.ALUControl = 3'($urandom);
  endtask

  task automatic receive(input string name, input int hold);
    exp_t e;
    int c;
    int busy_bad;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s_queue size=0 required 1", name);
      return;
    end
    e = sb.pop_front();
    c = 1;
    busy_bad = 0;
    while (bus.out_valid !== 1'b1 && c < 200) begin
      if (bus.in_ready !== 1'b0) busy_bad++;
      @(negedge clk);
      c++;
    end
    checks++;
    if (c != e.lat) begin
      failures++;
      $display("FAIL %s_latency got=%0d required=%0d", name, c, e.lat);
    end
    checks++;
    if (busy_bad != 0) begin
      failures++;
      $display("FAIL %s_busy in_ready high %0d cycles required 0", name, busy_bad);
    end
    checks++;
    if (bus.result !== e.res) begin
      failures++;
      $display("FAIL %s_result got=%h required=%h", name, bus.result, e.res);
    end
    checks++;
    if (bus.flags !== e.flg) begin
      failures++;
      $display("FAIL %s_flags got=%h required=%h", name, bus.flags, e.flg);
    end
    last_res = bus.result;
    last_flg = bus.flags;
    for (int k = 0; k < hold; k++) begin
      bus.out_ready = 1'b0;
      bus.in_valid = ~bus.in_valid;
      bus.A = {$urandom, $urandom, $urandom, $urandom};
      bus.B = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.result !== last_res || bus.flags !== last_flg) begin
        failures++;
        $display("FAIL %s_hold cycle=%0d valid=%b ready=%b result=%h flags=%h required 1 0 %h %h",
                 name, k, bus.out_valid, bus.in_ready, bus.result, bus.flags, last_res, last_flg);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_release ready=%b valid=%b required 1 0", name, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.A = '0; bus.B = '0; bus.ALUControl = 3'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== '0 || bus.flags !== '0) begin
      failures++;
      $display("FAIL reset_outputs valid=%b result=%h flags=%h required 0", bus.out_valid, bus.result, bus.flags);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready in_ready=%b required 1", bus.in_ready);
    end
  endtask

  task automatic test_add();
    send({32'h7FFFFFFF, 32'd1, 32'd30, 32'd10}, {32'd1, 32'hFFFFFFFF, 32'd10, 32'd20}, 3'b000);
    receive("add", 0);
    checks++;
    if (last_res !== 128'h80000000_00000000_00000028_0000001E || last_flg !== 16'h9600) begin
      failures++;
      $display("FAIL add_vector result=%h flags=%h required 80000000000000000000002800000001e 9600", last_res, last_flg);
    end
  endtask

  task automatic test_sub();
    send({32'd0, 32'd0, 32'd10, 32'd30}, {32'd0, 32'd0, 32'd20, 32'd10}, 3'b001);
    receive("sub", 0);
    checks++;
    if (last_res !== 128'h00000000_00000000_FFFFFFF6_00000014 || last_flg !== 16'h44A0) begin
      failures++;
      $display("FAIL sub_vector result=%h flags=%h required 0000000000000000fffffff600000014 44a0", last_res, last_flg);
    end
  endtask

  task automatic test_mul();
    send({32'd0, 32'd0, 32'h10000, 32'd4}, {32'd0, 32'd0, 32'h10000, 32'd5}, 3'b010);
    receive("mul", 0);
    checks++;
    if (last_res !== 128'h00000000_00000000_00000000_00000014 || last_flg !== 16'h4450) begin
      failures++;
      $display("FAIL mul_vector result=%h flags=%h required 00000000000000000000000000000014 4450", last_res, last_flg);
    end
  endtask

  task automatic test_shift_logic();
    send({32'hFFFFFFFF, 32'd1, 32'd1, 32'd1}, {32'hFFFFFFFF, 32'd31, 32'd32, 32'd2}, 3'b011);
    receive("sll", 0);
    checks++;
    if (last_res !== 128'h00000000_80000000_00000000_00000004 || last_flg !== 16'h4840) begin
      failures++;
      $display("FAIL sll_vector result=%h flags=%h required 00000000800000000000000000000004 4840", last_res, last_flg);
    end
    send({32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'd4}, {32'd4, 32'd32, 32'd31, 32'd1}, 3'b111);
    receive("srl", 0);
    checks++;
    if (last_res !== 128'h0FFFFFFF_00000000_00000001_00000002 || last_flg !== 16'h0400) begin
      failures++;
      $display("FAIL srl_vector result=%h flags=%h required 0fffffff000000000000000100000002 0400", last_res, last_flg);
    end
    send({4{32'hF0F0F0F0}}, {4{32'h0F0F0F0F}}, 3'b101);
    receive("xor", 0);
    checks++;
    if (last_res !== {4{32'hFFFFFFFF}} || last_flg !== 16'h8888) begin
      failures++;
      $display("FAIL xor_vector result=%h flags=%h required all-ones 8888", last_res, last_flg);
    end
    send({4{32'hF0F0F0F0}}, {4{32'h0F0F0F0F}}, 3'b100);
    receive("and", 0);
    send({32'h12345678, 32'h0, 32'hF0F0F0F0, 32'h1}, {32'h0, 32'h0, 32'h0F0F0F0F, 32'h2}, 3'b110);
    receive("or", 0);
  endtask

  task automatic test_backpressure();
    send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 3'b000);
    receive("backpressure", 5);
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    send({32'd3, 32'd7, 32'd9, 32'd11}, {32'd5, 32'd6, 32'd7, 32'd8}, 3'b010);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== '0 || bus.flags !== '0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midmul_reset valid=%b result=%h flags=%h ready=%b required 0 0 0 1",
               bus.out_valid, bus.result, bus.flags, bus.in_ready);
    end
    rst_n = 1'b1;
    sb.delete();
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL midmul_discard out_valid high %0d cycles required 0", seen);
    end
    send({32'd1, 32'd2, 32'd3, 32'd4}, {32'd4, 32'd3, 32'd2, 32'd1}, 3'b000);
    receive("post_reset_add", 0);
  endtask

  task automatic test_back_to_back();
    logic [2:0] op;
    logic [W-1:0] a, b;
    for (int t = 0; t < 10; t++) begin
      op = 3'($urandom);
      a = {$urandom, $urandom, $urandom, $urandom};
      if (op == 3'b011 || op == 3'b111)
        b = {32'($urandom_range(0, 40)), 32'($urandom_range(0, 40)),
             32'($urandom_range(0, 40)), 32'($urandom_range(0, 40))};
      else
        b = {$urandom, $urandom, $urandom, $urandom};
      send(a, b, op);
      receive("random", 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_shift_logic();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
